// File: rtl/rv_dm_wb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// rv_dm_wb_bridge_pkg
//   Shared definitions for the CPU data-port to Wishbone bridge:
//   bridge FSM state encoding, the default word returned on failed loads,
//   timeout counter width and an address word-alignment helper.
// -----------------------------------------------------------------------------
package rv_dm_wb_bridge_pkg;

    typedef enum logic [1:0] {
        BR_IDLE  = 2'd0,
        BR_ISSUE = 2'd1,
        BR_WAIT  = 2'd2,
        BR_DONE  = 2'd3
    } br_state_t;

    localparam logic [31:0] RV_ERROR_WORD = 32'h0000_0000;
    localparam int unsigned RV_TMO_W      = 16;

    // Wishbone addresses are word addresses; byte position travels in sel.
    function automatic logic [31:0] word_align(input logic [31:0] i_addr);
        return {i_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv_bus_timeout.sv
// -----------------------------------------------------------------------------
// rv_bus_timeout
//   Saturating cycle counter guarding one bus access.
//   Ports:
//     clk_i, rst_i  clock, synchronous active-high reset
//     i_clear       restart counting (asserted when a new access is accepted)
//     i_enable      count this cycle (access outstanding)
//     o_expired     this enabled cycle is the g_timeout-th one of the access
// -----------------------------------------------------------------------------
module rv_bus_timeout
    import rv_dm_wb_bridge_pkg::*;
#(
    parameter int unsigned g_timeout = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [RV_TMO_W-1:0] LP_LIMIT = RV_TMO_W'(g_timeout);
    localparam logic [RV_TMO_W-1:0] LP_LAST  = RV_TMO_W'(g_timeout - 1);

    // Number of enabled cycles already completed since the last clear.
    logic [RV_TMO_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LP_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flag the last permitted cycle so the FSM completes at its end edge.
    assign o_expired = i_enable && (r_count >= LP_LAST);

endmodule

// File: rtl/rv_dm_wb_bridge.sv
// -----------------------------------------------------------------------------
// rv_dm_wb_bridge
//   Turns each CPU data-memory load or store into one Wishbone B4 pipelined
//   single-beat cycle. A bus timeout completes the access with an error so a
//   missing slave cannot hang the core.
//   Ports:
//     clk_i, rst_i              clock, synchronous active-high reset
//     dm_*_i                    CPU request: address, store data, byte enables,
//                               load / store strobes
//     dm_ready_o                bridge idle, request accepted this cycle
//     dm_data_l_o               load data, valid with dm_load_done_o
//     dm_load_done_o            one-cycle load completion
//     dm_store_done_o           one-cycle store completion
//     wb_*_o / wb_*_i           Wishbone pipelined master port
//     bus_error_o               one-cycle pulse on bus error or timeout
//     bus_err_addr_o            request address of the last failed access
// -----------------------------------------------------------------------------
module rv_dm_wb_bridge
    import rv_dm_wb_bridge_pkg::*;
#(
    parameter int unsigned g_timeout    = 255,
    parameter logic [31:0] g_error_data = RV_ERROR_WORD
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    output logic        bus_error_o,
    output logic [31:0] bus_err_addr_o
);

    br_state_t   r_state;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_we;
    logic        r_cyc;
    logic        r_stb;
    logic [31:0] r_req_addr;
    logic [31:0] r_data_l;
    logic        r_load_done;
    logic        r_store_done;
    logic        r_bus_error;
    logic [31:0] r_err_addr;

    logic w_accept;
    logic w_tmo_enable;
    logic w_expired;
    logic w_bus_resp;
    logic w_ok;
    logic w_fail;
    logic w_finish;

    assign w_accept     = (r_state == BR_IDLE) && (dm_load_i || dm_store_i);
    assign w_tmo_enable = (r_state == BR_ISSUE) || (r_state == BR_WAIT);

    rv_bus_timeout #(
        .g_timeout (g_timeout)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_clear   (w_accept),
        .i_enable  (w_tmo_enable),
        .o_expired (w_expired)
    );

    // A slave response only counts once the strobe has been taken (stall low
    // in ISSUE) or while waiting. ack+err together is an error. A response in
    // the timeout cycle still wins over the timeout.
    always_comb begin
        w_bus_resp = ((r_state == BR_ISSUE) && !wb_stall_i) || (r_state == BR_WAIT);
        w_ok       = w_bus_resp && wb_ack_i && !wb_err_i;
        w_fail     = (w_bus_resp && wb_err_i) || (!w_ok && w_expired);
        w_finish   = w_ok || w_fail;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= BR_IDLE;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_req_addr   <= '0;
            r_data_l     <= '0;
            r_load_done  <= 1'b0;
            r_store_done <= 1'b0;
            r_bus_error  <= 1'b0;
            r_err_addr   <= '0;
        end else begin
            r_load_done  <= 1'b0;
            r_store_done <= 1'b0;
            r_bus_error  <= 1'b0;

            if (w_finish) begin
                r_state      <= BR_DONE;
                r_cyc        <= 1'b0;
                r_stb        <= 1'b0;
                r_load_done  <= !r_we;
                r_store_done <= r_we;
                if (!r_we) begin
                    r_data_l <= w_fail ? g_error_data : wb_dat_i;
                end
                if (w_fail) begin
                    r_bus_error <= 1'b1;
                    r_err_addr  <= r_req_addr;
                end
            end else begin
                case (r_state)
                    BR_IDLE: begin
                        if (w_accept) begin
                            // Store wins when both strobes are raised.
                            r_adr      <= word_align(dm_addr_i);
                            r_dat      <= dm_data_s_i;
                            r_sel      <= dm_data_select_i;
                            r_we       <= dm_store_i;
                            r_req_addr <= dm_addr_i;
                            r_cyc      <= 1'b1;
                            r_stb      <= 1'b1;
                            r_state    <= BR_ISSUE;
                        end
                    end
                    BR_ISSUE: begin
                        if (!wb_stall_i) begin
                            r_stb   <= 1'b0;
                            r_state <= BR_WAIT;
                        end
                    end
                    BR_WAIT: begin
                        r_state <= BR_WAIT;
                    end
                    BR_DONE: begin
                        r_state <= BR_IDLE;
                    end
                    default: begin
                        r_state <= BR_IDLE;
                    end
                endcase
            end
        end
    end

    assign dm_ready_o      = (r_state == BR_IDLE);
    assign dm_data_l_o     = r_data_l;
    assign dm_load_done_o  = r_load_done;
    assign dm_store_done_o = r_store_done;
    assign wb_adr_o        = r_adr;
    assign wb_dat_o        = r_dat;
    assign wb_sel_o        = r_sel;
    assign wb_we_o         = r_we;
    assign wb_cyc_o        = r_cyc;
    assign wb_stb_o        = r_stb;
    assign bus_error_o     = r_bus_error;
    assign bus_err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_rv_dm_wb_bridge.sv
// -----------------------------------------------------------------------------
// tb_rv_dm_wb_bridge
//   Self-checking bench for rv_dm_wb_bridge: directed vector table, randomized
//   transactions against a cycle-count reference model, and hand-written
//   sequences for reset mid-access and stray responses.
// -----------------------------------------------------------------------------
module tb_rv_dm_wb_bridge;

    localparam int unsigned TMO     = 8;
    localparam logic [31:0] ERR_W   = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_data_s_i = '0;
    logic [3:0]  dm_data_select_i = '0;
    logic        dm_load_i = 1'b0;
    logic        dm_store_i = 1'b0;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_stall_i = 1'b0;
    logic        bus_error_o;
    logic [31:0] bus_err_addr_o;

    rv_dm_wb_bridge #(
        .g_timeout    (TMO),
        .g_error_data (ERR_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_load_i        (dm_load_i),
        .dm_store_i       (dm_store_i),
        .dm_ready_o       (dm_ready_o),
        .dm_data_l_o      (dm_data_l_o),
        .dm_load_done_o   (dm_load_done_o),
        .dm_store_done_o  (dm_store_done_o),
        .wb_adr_o         (wb_adr_o),
        .wb_dat_o         (wb_dat_o),
        .wb_sel_o         (wb_sel_o),
        .wb_we_o          (wb_we_o),
        .wb_cyc_o         (wb_cyc_o),
        .wb_stb_o         (wb_stb_o),
        .wb_dat_i         (wb_dat_i),
        .wb_ack_i         (wb_ack_i),
        .wb_err_i         (wb_err_i),
        .wb_stall_i       (wb_stall_i),
        .bus_error_o      (bus_error_o),
        .bus_err_addr_o   (bus_err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // rtype: 0 silent slave, 1 ack, 2 err, 3 ack+err
    typedef struct {
        bit          store;
        bit          both;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          nstall;
        int          ndelay;
        int          rtype;
        logic [31:0] rdata;
        int          exp_done;   // cycle of the done pulse, request cycle = 0
        int          exp_nstb;
        bit          exp_err;
        logic [31:0] exp_ldata;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_err_addr = '0;
    logic [31:0] m_ldata = '0;
    vec_t        tbl [11];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit st, input bit bo, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] s,
                                input int ns, input int nd, input int rt,
                                input logic [31:0] rd, input int ed, input int eb,
                                input bit ee, input logic [31:0] el);
        vec_t v;
        v.store = st;  v.both = bo;  v.addr = a;  v.wdata = wd;  v.sel = s;
        v.nstall = ns; v.ndelay = nd; v.rtype = rt; v.rdata = rd;
        v.exp_done = ed; v.exp_nstb = eb; v.exp_err = ee; v.exp_ldata = el;
        return v;
    endfunction

    // Reference: the strobe is accepted in cycle nstall+1, the slave answers
    // ndelay cycles later; the access may last at most TMO cycles, and the
    // done pulse follows the completing cycle.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   resp;
        bit   answered;
        r        = v;
        resp     = v.nstall + 1 + v.ndelay;
        answered = (v.rtype != 0) && (resp <= int'(TMO));
        r.exp_done  = answered ? resp + 1 : int'(TMO) + 1;
        r.exp_nstb  = (v.nstall + 1 < int'(TMO)) ? v.nstall + 1 : int'(TMO);
        r.exp_err   = !answered || (v.rtype != 1);
        r.exp_ldata = r.exp_err ? ERR_W : v.rdata;
        return r;
    endfunction

    // Drives one request starting in the current cycle, plays the slave, and
    // leaves the bench one cycle after the done pulse (first ready cycle).
    task automatic run_txn(input vec_t v, input string tag);
        int          stall_cnt;
        int          acc;
        int          done_k;
        int          n_stb;
        int          nld;
        int          nsd;
        int          nerr;
        int          rdy_hi;
        logic [31:0] s_adr;
        logic [31:0] s_dat;
        logic [3:0]  s_sel;
        logic        s_we;
        logic [31:0] d_data;
        logic [31:0] d_eaddr;
        logic [31:0] exp_eaddr;

        chk({tag, " ready_t0"}, 32'(dm_ready_o), 32'd1);
        dm_addr_i        = v.addr;
        dm_data_s_i      = v.wdata;
        dm_data_select_i = v.sel;
        dm_store_i       = v.store;
        dm_load_i        = !v.store || v.both;
        wb_dat_i         = v.rdata;
        step();
        dm_load_i  = 1'b0;
        dm_store_i = 1'b0;

        stall_cnt = 0; acc = -1; done_k = -1; n_stb = 0;
        nld = 0; nsd = 0; nerr = 0; rdy_hi = 0;
        s_adr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0;
        d_data = '0; d_eaddr = '0;
        for (int k = 1; k <= 40; k++) begin
            if (dm_load_done_o)  nld++;
            if (dm_store_done_o) nsd++;
            if (bus_error_o)     nerr++;
            if (dm_load_done_o || dm_store_done_o) begin
                done_k  = k;
                d_data  = dm_data_l_o;
                d_eaddr = bus_err_addr_o;
                break;
            end
            if (dm_ready_o) rdy_hi++;
            wb_stall_i = 1'b0;
            wb_ack_i   = 1'b0;
            wb_err_i   = 1'b0;
            if (wb_stb_o) begin
                n_stb++;
                s_adr = wb_adr_o; s_dat = wb_dat_o; s_sel = wb_sel_o; s_we = wb_we_o;
                if (stall_cnt < v.nstall) begin
                    wb_stall_i = 1'b1;
                    stall_cnt++;
                end else if (acc < 0) begin
                    acc = k;
                end
            end
            if (acc >= 0 && k == acc + v.ndelay) begin
                wb_ack_i = (v.rtype == 1) || (v.rtype == 3);
                wb_err_i = (v.rtype == 2) || (v.rtype == 3);
            end
            step();
        end
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;

        exp_eaddr = v.exp_err ? v.addr : m_err_addr;
        chk({tag, " done_cycle"}, 32'(done_k), 32'(v.exp_done));
        chk({tag, " load_done"}, 32'(nld), v.store ? 32'd0 : 32'd1);
        chk({tag, " store_done"}, 32'(nsd), v.store ? 32'd1 : 32'd0);
        chk({tag, " stb_cycles"}, 32'(n_stb), 32'(v.exp_nstb));
        chk({tag, " wb_adr"}, s_adr, {v.addr[31:2], 2'b00});
        chk({tag, " wb_sel"}, 32'(s_sel), 32'(v.sel));
        chk({tag, " wb_we"}, 32'(s_we), 32'(v.store));
        if (v.store) chk({tag, " wb_dat"}, s_dat, v.wdata);
        chk({tag, " bus_error"}, 32'(nerr), 32'(v.exp_err));
        chk({tag, " err_addr"}, d_eaddr, exp_eaddr);
        chk({tag, " load_data"}, d_data, v.store ? m_ldata : v.exp_ldata);
        chk({tag, " ready_busy"}, 32'(rdy_hi), 32'd0);
        m_err_addr = exp_eaddr;
        if (!v.store) m_ldata = v.exp_ldata;

        step();
        chk({tag, " ready_after"}, 32'(dm_ready_o), 32'd1);
        chk({tag, " cyc_after"}, 32'(wb_cyc_o), 32'd0);
        chk({tag, " no_extra_done"}, 32'(dm_load_done_o | dm_store_done_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        //                store both addr           wdata          sel      ns nd rt rdata          done nstb err ldata
        tbl[0]  = mk(1'b0, 1'b0, 32'h2000_0010, 32'h0,         4'b1111, 0, 1, 1, 32'hCAFE_BABE, 3, 1, 1'b0, 32'hCAFE_BABE);
        tbl[1]  = mk(1'b1, 1'b0, 32'h0000_1003, 32'h1122_3344, 4'b1000, 3, 1, 1, 32'h0,         6, 4, 1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 32'h4000_0008, 32'h0,         4'b1111, 0, 0, 0, 32'h5555_5555, 9, 1, 1'b1, ERR_W);
        tbl[3]  = mk(1'b1, 1'b0, 32'h0000_2222, 32'hA5A5_0F0F, 4'b0011, 0, 0, 3, 32'h0,         2, 1, 1'b1, 32'h0);
        tbl[4]  = mk(1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'b1111, 0, 1, 1, 32'h1111_1111, 3, 1, 1'b0, 32'h1111_1111);
        tbl[5]  = mk(1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'b1111, 0, 2, 1, 32'h2222_2222, 4, 1, 1'b0, 32'h2222_2222);
        tbl[6]  = mk(1'b0, 1'b0, 32'h0000_0201, 32'h0,         4'b0010, 0, 1, 2, 32'h7777_7777, 3, 1, 1'b1, ERR_W);
        tbl[7]  = mk(1'b1, 1'b1, 32'h0000_2004, 32'h0BAD_F00D, 4'b1111, 0, 1, 1, 32'h9999_9999, 3, 1, 1'b0, 32'h0);
        tbl[8]  = mk(1'b1, 1'b0, 32'h0000_3000, 32'h1234_5678, 4'b1100, 20, 0, 1, 32'h0,        9, 8, 1'b1, 32'h0);
        tbl[9]  = mk(1'b0, 1'b0, 32'h0000_4000, 32'h0,         4'b1111, 2, 5, 1, 32'h3333_3333, 9, 3, 1'b0, 32'h3333_3333);
        tbl[10] = mk(1'b0, 1'b0, 32'h0000_5000, 32'h0,         4'b1111, 2, 6, 1, 32'h4444_4444, 9, 3, 1'b1, ERR_W);

        // Reset state
        step(); step(); step();
        chk("rst wb_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst wb_stb", 32'(wb_stb_o), 32'd0);
        chk("rst wb_we", 32'(wb_we_o), 32'd0);
        chk("rst wb_adr", wb_adr_o, 32'h0);
        chk("rst ready", 32'(dm_ready_o), 32'd1);
        chk("rst done", 32'(dm_load_done_o | dm_store_done_o), 32'd0);
        chk("rst data_l", dm_data_l_o, 32'h0);
        chk("rst bus_error", 32'(bus_error_o), 32'd0);
        chk("rst err_addr", bus_err_addr_o, 32'h0);
        rst_i = 1'b0;
        step();

        // Directed table, issued back-to-back
        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i], $sformatf("tbl%0d", i));
        end

        // Stray responses while idle must be ignored
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'hFFFF_0000;
        step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        chk("stray ready", 32'(dm_ready_o), 32'd1);
        chk("stray done", 32'(dm_load_done_o | dm_store_done_o), 32'd0);
        chk("stray bus_error", 32'(bus_error_o), 32'd0);
        chk("stray cyc", 32'(wb_cyc_o), 32'd0);
        chk("stray data_l", dm_data_l_o, m_ldata);

        // Reset asserted while waiting for the slave
        dm_addr_i = 32'h0000_6000;
        dm_data_select_i = 4'b1111;
        dm_load_i = 1'b1;
        step();
        dm_load_i = 1'b0;
        chk("rstmid issue_stb", 32'(wb_stb_o), 32'd1);
        step();
        chk("rstmid wait_cyc", 32'(wb_cyc_o), 32'd1);
        chk("rstmid wait_stb", 32'(wb_stb_o), 32'd0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rstmid cyc", 32'(wb_cyc_o), 32'd0);
        chk("rstmid ready", 32'(dm_ready_o), 32'd1);
        chk("rstmid done", 32'(dm_load_done_o | dm_store_done_o), 32'd0);
        m_ldata = '0;
        m_err_addr = '0;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0123_4567;
        step();
        wb_ack_i = 1'b0;
        chk("rstmid late_ack_done", 32'(dm_load_done_o | dm_store_done_o), 32'd0);
        chk("rstmid late_ack_ready", 32'(dm_ready_o), 32'd1);
        step();
        chk("rstmid late_ack_done2", 32'(dm_load_done_o | dm_store_done_o), 32'd0);
        chk("rstmid data_l", dm_data_l_o, 32'h0);

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            v.store  = ($urandom_range(0, 1) == 1);
            v.both   = v.store && ($urandom_range(0, 3) == 0);
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.sel    = 4'($urandom_range(0, 15));
            v.nstall = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
            v.ndelay = int'($urandom_range(0, 6));
            v.rtype  = int'($urandom_range(0, 3));
            v.rdata  = $urandom;
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
